// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load size.
package wb_pkg;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_MEM = 2'b00;
  localparam wb_sel_t WB_SEL_ALU = 2'b01;
  localparam wb_sel_t WB_SEL_PC4 = 2'b10;
  localparam wb_sel_t WB_SEL_IMM = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

endpackage

// File: rtl/wb_load_ext.sv
// Load lane extraction, sign/zero extension and misalignment detect. Purely combinational.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Select the addressed lane, then widen it to XLEN.
  always_comb begin
    byte_v   = mem_data[{addr_lo, 3'b000} +: 8];
    // Halfword lane comes from addr_lo[1] only; addr_lo[0] is ignored for data.
    half_v   = mem_data[{addr_lo[1], 4'b0000} +: 16];
    word_v   = mem_data[31:0];
    data     = mem_data;
    misalign = 1'b0;
    unique case (size)
      SZ_B: begin
        data = uns ? XLEN'(byte_v) : XLEN'($signed(byte_v));
      end
      SZ_H: begin
        data     = uns ? XLEN'(half_v) : XLEN'($signed(half_v));
        misalign = addr_lo[0];
      end
      SZ_W: begin
        // With XLEN=32 both casts are identity, so extension has no effect.
        data     = uns ? XLEN'(word_v) : XLEN'($signed(word_v));
        misalign = (addr_lo != 2'b00);
      end
      SZ_X: begin
        data     = mem_data;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: source mux, one-entry pipeline register, retire counter.
// Build option WB_LOAD_EXT_EN enables load extraction/extension and err_misalign.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       in_sel,
  input  logic             in_we,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_mem_data,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [1:0]       in_addr_lo,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             err_misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             capture;
  logic [XLEN-1:0]  ld_data;
  logic             ld_misalign;
  logic [XLEN-1:0]  sel_data;
  logic             sel_misalign;

  logic             valid_q;
  logic             we_q;
  logic [RA_W-1:0]  rd_q;
  logic [XLEN-1:0]  data_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  assign in_ready = !stall;
  // A flushed handshake still completes upstream but never enters the register.
  assign capture  = in_valid && in_ready && !flush;

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .mem_data(in_mem_data),
    .size    (in_size),
    .uns     (in_unsigned),
    .addr_lo (in_addr_lo),
    .data    (ld_data),
    .misalign(ld_misalign)
  );
`else
  assign ld_data     = in_mem_data;
  // Load-shape inputs are unused here; the AND folds to a constant 0.
  assign ld_misalign = 1'b0 & (^{in_size, in_unsigned, in_addr_lo});
`endif

  // Result-source mux; misalign only matters for memory loads.
  always_comb begin
    sel_data     = ld_data;
    sel_misalign = 1'b0;
    unique case (wb_sel_t'(in_sel))
      WB_SEL_MEM: begin
        sel_data     = ld_data;
        sel_misalign = ld_misalign;
      end
      WB_SEL_ALU: sel_data = in_alu;
      WB_SEL_PC4: sel_data = in_pc4;
      WB_SEL_IMM: sel_data = in_imm;
      default: ;
    endcase
  end

  // Pipeline register and retire counter; the entry lives for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= capture;
      mis_q   <= capture && sel_misalign;
      if (capture) begin
        we_q   <= in_we;
        rd_q   <= in_rd;
        data_q <= sel_data;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  // x0 writes are dropped here, but the instruction has already retired.
  assign rf_we        = valid_q && we_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = data_q;
  assign err_misalign = mis_q;
  assign retire_cnt   = cnt_q;

endmodule
